dcache_mem_responder: RTL and testbench

DCACHE_MEM_RESPONDER -- requirements
Module: dcache_mem_responder

---
 rtl/dcache_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_dcache_mem_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_responder.sv
// dcache_mem_responder: in-order request FIFO feeding a single-port SRAM.
// Optional range check: define DCACHE_MEM_RSP_ERR_EN.
module dcache_mem_responder #(
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned TidWidth     = 2,
  parameter int unsigned FifoDepth    = 4,
  parameter logic [63:0] RegionBase   = 64'h8000_0000,
  parameter logic [63:0] RegionLength = 64'h4000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_be_i,
  input  logic [TidWidth-1:0]    req_tid_i,
  output logic                   sram_req_o,
  output logic                   sram_we_o,
  output logic [AddrWidth-1:0]   sram_addr_o,
  output logic [DataWidth-1:0]   sram_wdata_o,
  output logic [DataWidth/8-1:0] sram_be_o,
  input  logic [DataWidth-1:0]   sram_rdata_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_we_o,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic [TidWidth-1:0]    rsp_tid_o,
  output logic                   rsp_err_o
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned PtrWidth = $clog2(FifoDepth);
  localparam int unsigned CntWidth = $clog2(FifoDepth + 1);

  typedef struct packed {
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [BeWidth-1:0]   be;
    logic [TidWidth-1:0]  tid;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  req_t                mem_q [FifoDepth];
  logic [PtrWidth-1:0] wptr_q;
  logic [PtrWidth-1:0] rptr_q;
  logic [CntWidth-1:0] cnt_q;
  state_t              state_q;

  logic                 rsp_we_q;
  logic                 rsp_err_q;
  logic [TidWidth-1:0]  rsp_tid_q;
  logic [DataWidth-1:0] rsp_rdata_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic acc_err;
  req_t head;
  req_t wr_entry;

  assign full        = (cnt_q == CntWidth'(FifoDepth));
  assign empty       = (cnt_q == '0);
  assign req_ready_o = ~full;
  assign push        = req_valid_i & ~full;
  assign pop         = (state_q == IDLE) & ~empty;
  assign head        = mem_q[rptr_q];

  assign wr_entry = '{
    we:    req_we_i,
    addr:  req_addr_i,
    wdata: req_wdata_i,
    be:    req_be_i,
    tid:   req_tid_i
  };

`ifdef DCACHE_MEM_RSP_ERR_EN
  // One extra bit so base+length cannot wrap around the address space.
  localparam logic [AddrWidth:0] RegLo =
    (AddrWidth+1)'(RegionBase);
  localparam logic [AddrWidth:0] RegHi =
    (AddrWidth+1)'(RegionBase) + (AddrWidth+1)'(RegionLength);

  assign acc_err = ({1'b0, head.addr} < RegLo) |
                   ({1'b0, head.addr} >= RegHi);
`else
  assign acc_err = 1'b0;
`endif

  // SRAM strobe is issued in the same cycle the head entry is popped.
  assign sram_req_o   = pop & ~acc_err;
  assign sram_we_o    = sram_req_o & head.we;
  assign sram_addr_o  = sram_req_o ? head.addr  : '0;
  assign sram_wdata_o = sram_req_o ? head.wdata : '0;
  assign sram_be_o    = sram_req_o ? head.be    : '0;

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_we_o    = rsp_valid_o & rsp_we_q;
  assign rsp_err_o   = rsp_valid_o & rsp_err_q;
  assign rsp_tid_o   = rsp_valid_o ? rsp_tid_q   : '0;
  assign rsp_rdata_o = rsp_valid_o ? rsp_rdata_q : '0;

  // FIFO storage, write on accepted request.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= wr_entry;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Request sequencer: IDLE pops, ACCESS captures read data, RESP waits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            rsp_we_q    <= head.we;
            rsp_tid_q   <= head.tid;
            rsp_err_q   <= acc_err;
            rsp_rdata_q <= '0;
            state_q     <= acc_err ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          rsp_rdata_q <= rsp_we_q ? '0 : sram_rdata_i;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// tb_dcache_mem_responder: directed scoreboard bench for dcache_mem_responder.
// Out-of-range expectations follow DCACHE_MEM_RSP_ERR_EN.
module tb_dcache_mem_responder;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [7:0]  req_be_i;
  logic [1:0]  req_tid_i;
  logic        sram_req_o;
  logic        sram_we_o;
  logic [63:0] sram_addr_o;
  logic [63:0] sram_wdata_o;
  logic [7:0]  sram_be_o;
  logic [63:0] sram_rdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_we_o;
  logic [63:0] rsp_rdata_o;
  logic [1:0]  rsp_tid_o;
  logic        rsp_err_o;

  dcache_mem_responder dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_be_i     (req_be_i),
    .req_tid_i    (req_tid_i),
    .sram_req_o   (sram_req_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_be_o    (sram_be_o),
    .sram_rdata_i (sram_rdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_we_o     (rsp_we_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_tid_o    (rsp_tid_o),
    .rsp_err_o    (rsp_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  tid;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   rsp_cnt  = 0;

`ifdef DCACHE_MEM_RSP_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  function automatic logic [63:0] rd_model(input logic [63:0] a);
    if (a == 64'h8000_0010) return 64'hDEAD_BEEF_0123_4567;
    return {a[31:0] ^ 32'h5A5A_A5A5, ~a[31:0]};
  endfunction

  function automatic bit out_of_range(input logic [63:0] a);
    return (a < 64'h8000_0000) || (a >= 64'hC000_0000);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // SRAM model: read data one cycle after the strobe; garbage otherwise.
  always @(posedge clk) begin
    sram_rdata_i <= sram_req_o ? rd_model(sram_addr_o)
                               : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  // Response monitor: pop and compare at every response handshake.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (!rst_i && rsp_valid_o && rsp_ready_i) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_tid",   64'(rsp_tid_o),   64'(e.tid));
        check("rsp_we",    64'(rsp_we_o),    64'(e.we));
        check("rsp_rdata", rsp_rdata_o,      e.rdata);
        check("rsp_err",   64'(rsp_err_o),   64'(e.err));
      end
    end
  end

  task automatic send(input logic we, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [7:0] be,
                      input logic [1:0] tid);
    exp_t e;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_be_i    = be;
    req_tid_i   = tid;
    if (req_ready_o) begin
      e.we    = we;
      e.tid   = tid;
      e.err   = ErrEn && out_of_range(addr);
      e.rdata = (we || e.err) ? 64'd0 : rd_model(addr);
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int          base;
    logic [63:0] held;
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_be_i    = '0;
    req_tid_i   = '0;
    rsp_ready_i = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_sram_req",  64'(sram_req_o),  64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Load with latency check.
    send(1'b0, 64'h8000_0010, 64'd0, 8'h00, 2'd1);
    idle();
    check("ld_sram_req",  64'(sram_req_o), 64'd1);
    check("ld_sram_we",   64'(sram_we_o),  64'd0);
    check("ld_sram_addr", sram_addr_o,     64'h8000_0010);
    @(negedge clk);
    check("ld_n2_valid",  64'(rsp_valid_o), 64'd0);
    check("ld_n2_sreq",   64'(sram_req_o),  64'd0);
    check("ld_n2_saddr",  sram_addr_o,      64'd0);
    @(negedge clk);
    check("ld_n3_valid",  64'(rsp_valid_o), 64'd1);
    wait_drain("ld_drain");

    // Store.
    send(1'b1, 64'h8000_0008, 64'h11, 8'h01, 2'd2);
    idle();
    check("st_sram_req",   64'(sram_req_o), 64'd1);
    check("st_sram_we",    64'(sram_we_o),  64'd1);
    check("st_sram_be",    64'(sram_be_o),  64'h01);
    check("st_sram_wdata", sram_wdata_o,    64'h11);
    repeat (2) @(negedge clk);
    check("st_n3_valid",   64'(rsp_valid_o), 64'd1);
    wait_drain("st_drain");

    // Backpressure: 6 back-to-back requests, response stalled.
    rsp_ready_i = 1'b0;
    base = rsp_cnt;
    for (int i = 0; i < 6; i++) begin
      send(1'b0, 64'h8000_0100 + 64'(8 * i), 64'd0, 8'h00, 2'(i));
    end
    idle();
    repeat (2) @(negedge clk);
    check("bp_accepted",  64'(sb.size()),   64'd5);
    check("bp_ready",     64'(req_ready_o), 64'd0);
    check("bp_valid",     64'(rsp_valid_o), 64'd1);
    check("bp_tid",       64'(rsp_tid_o),   64'd0);
    held = rsp_rdata_o;
    repeat (3) @(negedge clk);
    check("bp_hold",      rsp_rdata_o,      held);
    check("bp_hold_data", rsp_rdata_o,      rd_model(64'h8000_0100));
    rsp_ready_i = 1'b1;
    wait_drain("bp_drain");
    check("bp_count", 64'(rsp_cnt - base), 64'd5);

    // Out-of-range load.
    send(1'b0, 64'h0000_1000, 64'd0, 8'h00, 2'd3);
    idle();
    check("oor_sram_req", 64'(sram_req_o), ErrEn ? 64'd0 : 64'd1);
    @(negedge clk);
    check("oor_n2_valid", 64'(rsp_valid_o), ErrEn ? 64'd1 : 64'd0);
    wait_drain("oor_drain");

    // Random traffic with random backpressure (exercises pointer wrap).
    for (int i = 0; i < 24; i++) begin
      rsp_ready_i = 1'($urandom_range(0, 1));
      send(1'($urandom_range(0, 1)),
           64'h8000_0000 + 64'($urandom_range(0, 255) * 8),
           64'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
    end
    idle();
    rsp_ready_i = 1'b1;
    wait_drain("rnd_drain");

    // Reset while in ACCESS with 3 requests queued.
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 64'h8000_0200 + 64'(8 * i), 64'd0, 8'h00, 2'(i));
    end
    idle();
    repeat (2) @(negedge clk);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check("rr_idle_sreq", 64'(sram_req_o), 64'd1);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("rr_req_ready", 64'(req_ready_o),  64'd1);
    check("rr_sram_req",  64'(sram_req_o),   64'd0);
    check("rr_sram_addr", sram_addr_o,       64'd0);
    check("rr_rsp_valid", 64'(rsp_valid_o),  64'd0);
    check("rr_rsp_rdata", rsp_rdata_o,       64'd0);
    check("rr_rsp_tid",   64'(rsp_tid_o),    64'd0);
    check("rr_rsp_err",   64'(rsp_err_o),    64'd0);
    sb.delete();
    base = rsp_cnt;
    repeat (2) @(negedge clk);
    rst_i       = 1'b0;
    rsp_ready_i = 1'b1;
    repeat (10) @(negedge clk);
    check("rr_no_rsp",   64'(rsp_cnt - base), 64'd0);
    check("rr_no_sreq",  64'(sram_req_o),     64'd0);

    // Still functional after reset.
    send(1'b0, 64'h8000_0040, 64'd0, 8'h00, 2'd2);
    idle();
    wait_drain("post_rst_drain");
    check("post_rst_count", 64'(rsp_cnt - base), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
